pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the multi-cycle pipelined CPU: carries NCH lanes of DW bits (lane 0 = PC, lane 1 = instruction, further lanes = stage payload) from one pipeline stage to the next. Compared with a plain capture register, it adds a valid bit, stall (hold), flush (bubble insertion) and a stall-age counter. Optional saturating performance counters are included. One instance sits between each pair of stages (F/D, D/E, E/M, M/W).

## Interface
Parameters:
- DW, 32, width of one lane in bits
- NCH, 2, number of lanes (≥1); lane k occupies bits [k*DW +: DW]
- RST_LANE0, 32'h0000_3000, reset value of lane 0 (PC); truncated/zero-extended to DW
- KEEP_LANE0, 1, on flush: 1 = lane 0 loads incoming lane 0, 0 = lane 0 loads RST_LANE0
- AGE_W, 4, width of hold_age
- CNT_W, 32, width of performance counters

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream stage holds a real instruction
- in_data  input  NCH*DW  upstream lanes
- stall  input  1  hold current contents
- flush  input  1  replace contents with a bubble
- out_valid  output  1  registered valid
- out_data  output  NCH*DW  registered lanes
- hold_age  output  AGE_W  consecutive cycles current contents have been held
- stall_cnt  output  CNT_W  total stalled cycles with out_valid=1 (perf)
- bubble_cnt  output  CNT_W  total bubbles loaded (perf)

## Operation
- Per-edge priority: reset > flush > stall > load.
- Reset (async, immediate): out_valid=0, lane 0=RST_LANE0, lanes 1..NCH-1=0, hold_age=0, stall_cnt=0, bubble_cnt=0.
- Flush (regardless of stall): out_valid←0; lanes 1..NCH-1←0 (NOP = 32'h0); lane 0←in_data lane 0 if KEEP_LANE0=1, else RST_LANE0; hold_age←0.
- Stall (flush=0): all lanes and out_valid hold; hold_age←hold_age+1, saturating at 2^AGE_W−1.
- Load (flush=0, stall=0): out_valid←in_valid; all lanes←in_data (captured even when in_valid=0); hold_age←0.
- Bubble event = flush edge, or load edge with in_valid=0.
- Stall event = stall=1, flush=0, out_valid=1 at the edge (holding a bubble is not counted).
- NCH=1: lane 0 only; flush affects no other lanes.
- Reset asserted mid-stall or mid-flush: async reset wins at once; the first edge after deassertion follows the normal priority.

## Timing
- Latency 1 cycle: in_data sampled at edge N appears on out_data after edge N.
- Outputs purely registered; no combinational path from inputs to outputs.
- stall/flush sampled at the same edge as in_data; effect visible after that edge.
- Counters and hold_age update on the same edge as the data.
- Counters and hold_age saturate (no wrap).

## Configuration
- PIPE_PERF_EN defined: stall_cnt and bubble_cnt count stall and bubble events, +1 per event, saturating at 2^CNT_W−1.
- PIPE_PERF_EN undefined: stall_cnt and bubble_cnt ports remain, are driven constant 0, and no counter flops are synthesised. All other behaviour is identical.

## Test plan
- Reset release: assert reset mid-cycle with NCH=2 → out_valid=0, out_data={32'h0, 32'h0000_3000} without waiting for an edge; counters 0.
- Plain load: in_valid=1, in_data={32'h2408_0005, 32'h0000_3004}, stall=0, flush=0 → one edge later out_valid=1 and the same lanes appear; hold_age=0.
- Stall run: after the load, stall=1 for 20 edges with AGE_W=4 → out_data unchanged, hold_age=15 (saturated), stall_cnt=20 with the macro, 0 without.
- Flush beats stall: with PC 32'h0000_3010 held, drive flush=1, stall=1, incoming lane 0=32'h0000_3014 → out_valid=0, lane 1=0, lane 0=32'h0000_3014 (KEEP_LANE0=1) or 32'h0000_3000 (KEEP_LANE0=0); bubble_cnt +1.
- Invalid load: in_valid=0, stall=0, flush=0, in_data={32'hDEAD_BEEF, 32'h0000_3020} → out_valid=0, lanes captured verbatim, bubble_cnt +1; a subsequent stall does not increment stall_cnt.
- Async reset mid-stall: with hold_age=7 and stall=1, pulse reset between edges → all outputs return to reset values immediately; the next edge with stall=0 and in_valid=1 loads normally.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: 1-cycle latency, priority reset > flush > stall > load, saturating hold_age.
// Define PIPE_PERF_EN to build the saturating stall_cnt/bubble_cnt counters; otherwise those ports tie to 0.
module pipe_stage_reg #(
  parameter int unsigned DW         = 32,
  parameter int unsigned NCH        = 2,
  parameter logic [31:0] RST_LANE0  = 32'h0000_3000,
  parameter bit          KEEP_LANE0 = 1'b1,
  parameter int unsigned AGE_W      = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [NCH*DW-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [NCH*DW-1:0] out_data,
  output logic [AGE_W-1:0]  hold_age,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned    W        = NCH * DW;
  localparam logic [DW-1:0]  RST_L0   = DW'(RST_LANE0);
  // Lane 0 holds the reset PC, every upper lane is zero (a NOP).
  localparam logic [W-1:0]   RST_DATA = W'(RST_L0);

  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [DW-1:0]    flush_l0;

  always_comb begin
    flush_l0 = KEEP_LANE0 ? in_data[DW-1:0] : RST_L0;
    valid_d  = valid_q;
    data_d   = data_q;
    age_d    = age_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = W'(flush_l0);
      age_d   = '0;
    end else if (stall) begin
      if (age_q != '1) age_d = age_q + AGE_W'(1);
    end else begin
      valid_d = in_valid;
      data_d  = in_data;
      age_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RST_DATA;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      age_q   <= age_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign hold_age  = age_q;

`ifdef PIPE_PERF_EN
  logic             stall_ev, bubble_ev;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Holding a bubble is not a stall; an invalid load counts as a bubble.
  assign stall_ev  = !flush && stall && valid_q;
  assign bubble_ev = flush || (!stall && !in_valid);

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_ev && (stall_cnt_q != '1))   stall_cnt_d  = stall_cnt_q + CNT_W'(1);
    if (bubble_ev && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
